// File: rtl/cic_pkg.sv
// Shared sizing helpers and parameter legality checks for the CIC decimator.
package cic_pkg;

  localparam int MAX_STAGES = 6;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int acc_width(input int in_w, input int stages, input int dec);
    return in_w + stages * clog2(dec);
  endfunction

  function automatic bit params_ok(input int in_w, input int out_w, input int dec, input int stages);
    return (dec >= 2) && ((dec & (dec - 1)) == 0) &&
           (stages >= 1) && (stages <= MAX_STAGES) &&
           (in_w >= 2) && (out_w >= 1) && (out_w <= acc_width(in_w, stages, dec));
  endfunction

endpackage

// File: rtl/cic_channel.sv
// One CIC data path: input register, pipelined integrator chain, decimation tap and comb chain.
module cic_channel
  import cic_pkg::*;
#(
  parameter int IN_W   = 17,
  parameter int OUT_W  = 17,
  parameter int ACC_W  = 26,
  parameter int STAGES = 3
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_in_en,
  input  logic [IN_W-1:0]   i_data,
  input  logic [STAGES-1:0] i_int_en,
  input  logic              i_dec_en,
  input  logic [STAGES-1:0] i_comb_en,
  output logic [OUT_W-1:0]  o_data
);

  logic signed [ACC_W-1:0] r_in;
  logic signed [ACC_W-1:0] r_dec;
  logic signed [ACC_W-1:0] r_int  [STAGES];
  logic signed [ACC_W-1:0] r_comb [STAGES];
  logic signed [ACC_W-1:0] r_prev [STAGES];
  logic signed [ACC_W-1:0] w_int_src  [STAGES];
  logic signed [ACC_W-1:0] w_comb_src [STAGES];
  logic signed [ACC_W-1:0] w_ext;

  assign w_ext = {{(ACC_W - IN_W){i_data[IN_W-1]}}, i_data};

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_int_src[k]  = r_in;
      w_comb_src[k] = r_dec;
    end
    for (int k = 1; k < STAGES; k++) begin
      w_int_src[k]  = r_int[k-1];
      w_comb_src[k] = r_comb[k-1];
    end
  end

  // Each stage only moves when its own valid bit arrives, so input gaps never change results.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_in  <= '0;
      r_dec <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_int[k]  <= '0;
        r_comb[k] <= '0;
        r_prev[k] <= '0;
      end
    end else begin
      if (i_in_en) r_in <= w_ext;
      if (i_dec_en) r_dec <= r_int[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        if (i_int_en[k]) r_int[k] <= r_int[k] + w_int_src[k];
        if (i_comb_en[k]) begin
          r_comb[k] <= w_comb_src[k] - r_prev[k];
          r_prev[k] <= w_comb_src[k];
        end
      end
    end
  end

  assign o_data = r_comb[STAGES-1][ACC_W-1 -: OUT_W];

endmodule

// File: rtl/cic_decimator.sv
// Dual-channel (I/Q) CIC decimator: shared valid pipeline and decimation counter, two data paths.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = 17,
  parameter int OUTPUT_DATA_WIDTH = 17,
  parameter int DECIMATION        = 8,
  parameter int STAGES            = 3
) (
  input  logic                                i_clk,
  input  logic                                i_resetn,
  input  logic                                i_valid,
  input  logic signed [INPUT_DATA_WIDTH-1:0]  i_xIn,
  input  logic signed [INPUT_DATA_WIDTH-1:0]  i_yIn,
  output logic signed [OUTPUT_DATA_WIDTH-1:0] o_xOut,
  output logic signed [OUTPUT_DATA_WIDTH-1:0] o_yOut,
  output logic                                o_valid
);

  localparam int ACC_WIDTH = acc_width(INPUT_DATA_WIDTH, STAGES, DECIMATION);
  localparam int CNT_W     = clog2(DECIMATION);

  if (!params_ok(INPUT_DATA_WIDTH, OUTPUT_DATA_WIDTH, DECIMATION, STAGES)) begin : g_bad_params
    $error("cic_decimator: illegal DECIMATION/STAGES/width combination");
  end

  logic                         r_vin;
  logic [STAGES-1:0]            r_vint;
  logic [STAGES-1:0]            r_vcomb;
  logic                         r_vdec;
  logic [CNT_W-1:0]             r_cnt;
  logic [OUTPUT_DATA_WIDTH-1:0] r_xout;
  logic [OUTPUT_DATA_WIDTH-1:0] r_yout;
  logic                         r_valid;
  logic [STAGES:0]              w_int_chain;
  logic [STAGES:0]              w_comb_chain;
  logic [STAGES-1:0]            w_int_en;
  logic [STAGES-1:0]            w_comb_en;
  logic                         w_dec_en;
  logic [OUTPUT_DATA_WIDTH-1:0] w_xtrunc;
  logic [OUTPUT_DATA_WIDTH-1:0] w_ytrunc;

  assign w_int_chain  = {r_vint, r_vin};
  assign w_comb_chain = {r_vcomb, r_vdec};
  assign w_int_en     = w_int_chain[STAGES-1:0];
  assign w_comb_en    = w_comb_chain[STAGES-1:0];
  assign w_dec_en     = r_vint[STAGES-1] && (r_cnt == CNT_W'(DECIMATION - 1));

  // Valid pipeline, decimation counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_vin   <= 1'b0;
      r_vint  <= '0;
      r_vdec  <= 1'b0;
      r_vcomb <= '0;
      r_cnt   <= '0;
      r_xout  <= '0;
      r_yout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_vin   <= i_valid;
      r_vint  <= w_int_en;
      r_vdec  <= w_dec_en;
      r_vcomb <= w_comb_en;
      if (r_vint[STAGES-1]) r_cnt <= w_dec_en ? '0 : r_cnt + CNT_W'(1);
      r_valid <= r_vcomb[STAGES-1];
      if (r_vcomb[STAGES-1]) begin
        r_xout <= w_xtrunc;
        r_yout <= w_ytrunc;
      end
    end
  end

  cic_channel #(
    .IN_W(INPUT_DATA_WIDTH), .OUT_W(OUTPUT_DATA_WIDTH), .ACC_W(ACC_WIDTH), .STAGES(STAGES)
  ) u_chan_i (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_in_en(i_valid), .i_data(i_xIn),
    .i_int_en(w_int_en), .i_dec_en(w_dec_en), .i_comb_en(w_comb_en), .o_data(w_xtrunc)
  );

  cic_channel #(
    .IN_W(INPUT_DATA_WIDTH), .OUT_W(OUTPUT_DATA_WIDTH), .ACC_W(ACC_WIDTH), .STAGES(STAGES)
  ) u_chan_q (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_in_en(i_valid), .i_data(i_yIn),
    .i_int_en(w_int_en), .i_dec_en(w_dec_en), .i_comb_en(w_comb_en), .o_data(w_ytrunc)
  );

  assign o_xOut  = r_xout;
  assign o_yOut  = r_yout;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: ideal CIC reference model feeding a timed scoreboard, two DUT configurations.
module tb_cic_decimator;

  logic               clk = 1'b0;
  logic               resetn;
  logic               valid;
  logic signed [16:0] xin, yin;
  logic signed [16:0] x0, y0, x1, y1;
  logic               v0, v1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cic_decimator #(.INPUT_DATA_WIDTH(17), .OUTPUT_DATA_WIDTH(17), .DECIMATION(8), .STAGES(3)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_valid(valid), .i_xIn(xin), .i_yIn(yin),
    .o_xOut(x0), .o_yOut(y0), .o_valid(v0));

  cic_decimator #(.INPUT_DATA_WIDTH(17), .OUTPUT_DATA_WIDTH(17), .DECIMATION(8), .STAGES(1)) dut1 (
    .i_clk(clk), .i_resetn(resetn), .i_valid(valid), .i_xIn(xin), .i_yIn(yin),
    .o_xOut(x1), .o_yOut(y1), .o_valid(v1));

  typedef struct { int cyc; int x; int y; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t me;

  longint m_int  [2][2][6];
  longint m_prev [2][2][6];
  int     m_cnt  [2];
  int     checks = 0;
  int     errors = 0;
  int     npulse = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint wrapv(input longint v, input int w);
    longint s;
    s = v << (64 - w);
    return s >>> (64 - w);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0;
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 6; k++) begin
          m_int[d][c][k]  = 0;
          m_prev[d][c][k] = 0;
        end
    end
  endtask

  // Ideal (non-pipelined) CIC of order n, accumulator width w, R = 8.
  task automatic model_step(input int d, input int n, input int w, input int x, input int y);
    longint c, t, v;
    int     o [2];
    exp_t   e;
    for (int ch = 0; ch < 2; ch++) begin
      v = (ch == 0) ? longint'(x) : longint'(y);
      for (int k = 0; k < n; k++) begin
        if (k == 0) m_int[d][ch][k] = wrapv(m_int[d][ch][k] + v, w);
        else        m_int[d][ch][k] = wrapv(m_int[d][ch][k] + m_int[d][ch][k-1], w);
      end
    end
    if (m_cnt[d] == 7) begin
      for (int ch = 0; ch < 2; ch++) begin
        c = m_int[d][ch][n-1];
        for (int k = 0; k < n; k++) begin
          t = wrapv(c - m_prev[d][ch][k], w);
          m_prev[d][ch][k] = c;
          c = t;
        end
        o[ch] = int'(c >>> (w - 17));
      end
      // accepted on edge cyc+1, o_valid seen after edge cyc+1+(2n+2)
      e.cyc = cyc + 2 * n + 3;
      e.x = o[0];
      e.y = o[1];
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    m_cnt[d] = (m_cnt[d] + 1) % 8;
  endtask

  task automatic drive(input int x, input int y, input logic v);
    @(posedge clk);
    #1;
    valid = v;
    xin   = x[16:0];
    yin   = y[16:0];
    if (v && resetn) begin
      model_step(0, 3, 26, x, y);
      model_step(1, 1, 20, x, y);
    end
  endtask

  always @(negedge clk) begin
    if (v0) begin
      npulse++;
      if (q0.size() == 0) check("d0_spurious_valid", v0, 0);
      else begin
        me = q0.pop_front();
        check("d0_latency", cyc, me.cyc);
        check("d0_x", x0, me.x);
        check("d0_y", y0, me.y);
      end
    end else if (q0.size() > 0 && q0[0].cyc < cyc) begin
      me = q0.pop_front();
      check("d0_missing_valid", v0, 1);
    end
    if (v1) begin
      if (q1.size() == 0) check("d1_spurious_valid", v1, 0);
      else begin
        me = q1.pop_front();
        check("d1_latency", cyc, me.cyc);
        check("d1_x", x1, me.x);
        check("d1_y", y1, me.y);
      end
    end else if (q1.size() > 0 && q1[0].cyc < cyc) begin
      me = q1.pop_front();
      check("d1_missing_valid", v1, 1);
    end
  end

  typedef struct { int x; int y; int mode; int len; int ex; int ey; bit chk; } vec_t;
  vec_t tbl [5];

  initial begin
    int  n0;
    int  xv, yv;
    logic vv;
    tbl[0] = '{x: 1000,   y: -1000, mode: 1, len: 400, ex: 1000,   ey: -1000, chk: 1'b1};
    tbl[1] = '{x: -65536, y: 65535, mode: 0, len: 200, ex: -65536, ey: 65535, chk: 1'b1};
    tbl[2] = '{x: 12345,  y: -321,  mode: 2, len: 400, ex: 12345,  ey: -321,  chk: 1'b1};
    tbl[3] = '{x: 0,      y: 0,     mode: 3, len: 300, ex: 0,      ey: 0,     chk: 1'b0};
    tbl[4] = '{x: -7,     y: 7,     mode: 0, len: 160, ex: -7,     ey: 7,     chk: 1'b1};

    resetn = 1'b1; valid = 1'b0; xin = '0; yin = '0;
    model_reset();
    #1 resetn = 1'b0;
    #1;
    check("reset_valid", v0, 0);
    check("reset_x", x0, 0);
    check("reset_y", y0, 0);
    check("reset_valid_n1", v1, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    n0 = npulse;
    repeat (800) drive(1000, -1000, 1'b1);
    repeat (20) drive(0, 0, 1'b0);
    check("rate_pulses", npulse - n0, 100);
    check("dc_x", x0, 1000);
    check("dc_y", y0, -1000);
    check("dc_x_n1", x1, 1000);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < tbl[i].len; j++) begin
        case (tbl[i].mode)
          0:       vv = 1'b1;
          1:       vv = (j % 2 == 0);
          default: vv = 1'($urandom_range(0, 1));
        endcase
        xv = tbl[i].x;
        yv = tbl[i].y;
        if (tbl[i].mode == 3) begin
          xv = int'($urandom_range(0, 131071)) - 65536;
          yv = int'($urandom_range(0, 131071)) - 65536;
        end
        drive(xv, yv, vv);
      end
      repeat (20) drive(0, 0, 1'b0);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_x", i), x0, tbl[i].ex);
        check($sformatf("vec%0d_y", i), y0, tbl[i].ey);
      end
    end

    // Reset in the middle of a stream: everything in flight is dropped.
    repeat (13) drive(500, -500, 1'b1);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("midrst_valid", v0, 0);
    check("midrst_x", x0, 0);
    check("midrst_y", y0, 0);
    check("midrst_x_n1", x1, 0);
    q0.delete();
    q1.delete();
    model_reset();
    repeat (3) drive(500, -500, 1'b1);
    @(posedge clk);
    #1 resetn = 1'b1;
    valid = 1'b0;
    repeat (40) drive(500, -500, 1'b1);
    repeat (20) drive(0, 0, 1'b0);

    for (int i = 0; i < 60 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
